// File: rtl/detect_logger_pkg.sv
// Shared defaults and helpers for the detection event logger.
// Counters saturate instead of wrapping, so a stuck-high detector cannot alias a count.
package detect_logger_pkg;

    localparam int TS_W_DEFAULT  = 16;
    localparam int DEPTH_DEFAULT = 4;
    localparam int CNT_W_DEFAULT = 8;

    // Saturating increment for counters up to 32 bits wide; max_val is the ceiling.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] max_val);
        return (value >= max_val) ? max_val : value + 32'd1;
    endfunction

endpackage

// File: rtl/detect_event_logger_sync_fifo.sv
// Synchronous FIFO with level tracking; a write into a full FIFO is accepted
// only when a read retires the head in the same cycle.
module sync_fifo #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int LVL_W = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             wr_fire;
    logic             rd_fire;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        mem_d    = mem_q;

        rd_fire  = rd_en && (level_q != '0);
        wr_fire  = wr_en && ((level_q != LVL_FULL) || rd_fire);

        if (wr_fire) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (rd_fire) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        case ({wr_fire, rd_fire})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // NOTE: the storage array is not reset; an empty FIFO never exposes it because rd_data is gated.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign empty   = (level_q == '0);
    assign full    = (level_q == LVL_FULL);
    assign level   = level_q;
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/detect_event_logger.sv
// Timestamps detection pulses into a small event FIFO and keeps saturating
// detection/drop statistics plus a sticky overflow flag.
module detect_event_logger
    import detect_logger_pkg::*;
#(
    parameter  int TS_W  = TS_W_DEFAULT,
    parameter  int DEPTH = DEPTH_DEFAULT,
    parameter  int CNT_W = CNT_W_DEFAULT,
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             det_in,
    input  logic             en,
    input  logic             clr,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [TS_W-1:0]  evt_ts,
    output logic [LVL_W-1:0] fifo_level,
    output logic [CNT_W-1:0] det_cnt,
    output logic [CNT_W-1:0] drop_cnt,
    output logic             ovf
);

    localparam logic [TS_W-1:0]  TS_ONE  = TS_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [TS_W-1:0]  ts_q, ts_d;
    logic [CNT_W-1:0] det_cnt_q, det_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic             ovf_q, ovf_d;

    logic             flush;
    logic             capture;
    logic             pop;
    logic             drop;
    logic             fifo_full;
    logic             fifo_empty;

    always_comb begin
        ts_d       = ts_q;
        det_cnt_d  = det_cnt_q;
        drop_cnt_d = drop_cnt_q;
        ovf_d      = ovf_q;

        flush   = rst || clr;
        capture = en && det_in && !flush;
        pop     = !fifo_empty && evt_ready;
        // A capture into a full FIFO survives only if the head leaves in the same cycle.
        drop    = capture && fifo_full && !pop;

        if (flush) begin
            ts_d       = '0;
            det_cnt_d  = '0;
            drop_cnt_d = '0;
            ovf_d      = 1'b0;
        end else begin
            if (en) begin
                ts_d = ts_q + TS_ONE;
            end
            if (capture) begin
                det_cnt_d = CNT_W'(sat_inc(32'(det_cnt_q), 32'(CNT_MAX)));
            end
            if (drop) begin
                drop_cnt_d = CNT_W'(sat_inc(32'(drop_cnt_q), 32'(CNT_MAX)));
                ovf_d      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ts_q       <= '0;
            det_cnt_q  <= '0;
            drop_cnt_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            ts_q       <= ts_d;
            det_cnt_q  <= det_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            ovf_q      <= ovf_d;
        end
    end

    // The pushed timestamp is the pre-increment value of the capture cycle.
    sync_fifo #(
        .WIDTH (TS_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (flush),
        .wr_en   (capture),
        .wr_data (ts_q),
        .rd_en   (pop),
        .rd_data (evt_ts),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    assign evt_valid = !fifo_empty;
    assign det_cnt   = det_cnt_q;
    assign drop_cnt  = drop_cnt_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_detect_event_logger.sv
// Bench for detect_event_logger: a vector table for basic capture plus a
// timestamp scoreboard and reference counters for the multi-cycle scenarios.
module tb_detect_event_logger;

    logic        clk;
    logic        rst;
    logic        det_in;
    logic        en;
    logic        clr;
    logic        evt_valid;
    logic        evt_ready;
    logic [15:0] evt_ts;
    logic [2:0]  fifo_level;
    logic [7:0]  det_cnt;
    logic [7:0]  drop_cnt;
    logic        ovf;

    detect_event_logger dut (
        .clk        (clk),
        .rst        (rst),
        .det_in     (det_in),
        .en         (en),
        .clr        (clr),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_ts     (evt_ts),
        .fifo_level (fifo_level),
        .det_cnt    (det_cnt),
        .drop_cnt   (drop_cnt),
        .ovf        (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: expected FIFO contents and counters.
    logic [15:0] m_q[$];
    logic [15:0] m_ts = '0;
    int          m_det = 0;
    int          m_drop = 0;
    logic        m_ovf = 1'b0;

    typedef struct {
        logic det;
        logic en;
        logic rdy;
        logic exp_valid;
        int   exp_level;
        int   exp_ts;
        int   exp_det;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Applies one cycle of inputs, retires/pushes the scoreboard, then waits past the edge.
    task automatic drive(input logic d, input logic e, input logic c, input logic r, input logic rdy);
        logic popped;
        det_in    = d;
        en        = e;
        clr       = c;
        rst       = r;
        evt_ready = rdy;
        popped    = 1'b0;
        if (!r && !c && rdy && m_q.size() != 0) begin
            check("pop_ts", 32'(evt_ts), 32'(m_q[0]));
            void'(m_q.pop_front());
            popped = 1'b1;
        end
        if (r || c) begin
            m_ts   = '0;
            m_q.delete();
            m_det  = 0;
            m_drop = 0;
            m_ovf  = 1'b0;
        end else begin
            if (e && d) begin
                if (m_det < 255) m_det++;
                if (m_q.size() < 4) begin
                    m_q.push_back(m_ts);
                end else begin
                    if (m_drop < 255) m_drop++;
                    m_ovf = 1'b1;
                end
            end
            if (e) m_ts = m_ts + 16'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag);
        check({tag, ".valid"}, 32'(evt_valid), 32'(m_q.size() != 0));
        check({tag, ".level"}, 32'(fifo_level), 32'(m_q.size()));
        check({tag, ".ts"},    32'(evt_ts), (m_q.size() != 0) ? 32'(m_q[0]) : 32'd0);
        check({tag, ".det"},   32'(det_cnt), 32'(m_det));
        check({tag, ".drop"},  32'(drop_cnt), 32'(m_drop));
        check({tag, ".ovf"},   32'(ovf), 32'(m_ovf));
    endtask

    initial begin
        det_in = 0; en = 0; clr = 0; rst = 1; evt_ready = 0;

        // Reset state
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 1, 0);
        check("rst.valid", 32'(evt_valid), 32'd0);
        check("rst.level", 32'(fifo_level), 32'd0);
        check("rst.ts",    32'(evt_ts), 32'd0);
        check("rst.det",   32'(det_cnt), 32'd0);
        check("rst.drop",  32'(drop_cnt), 32'd0);
        check("rst.ovf",   32'(ovf), 32'd0);

        // Basic capture: pulses at ts=5, 9, 12, then drain on consecutive cycles
        vecs[0]  = '{0, 1, 0, 0, 0, 0,  0};
        vecs[1]  = '{0, 1, 0, 0, 0, 0,  0};
        vecs[2]  = '{0, 1, 0, 0, 0, 0,  0};
        vecs[3]  = '{0, 1, 0, 0, 0, 0,  0};
        vecs[4]  = '{0, 1, 0, 0, 0, 0,  0};
        vecs[5]  = '{1, 1, 0, 1, 1, 5,  1};
        vecs[6]  = '{0, 1, 0, 1, 1, 5,  1};
        vecs[7]  = '{0, 1, 0, 1, 1, 5,  1};
        vecs[8]  = '{0, 1, 0, 1, 1, 5,  1};
        vecs[9]  = '{1, 1, 0, 1, 2, 5,  2};
        vecs[10] = '{0, 1, 0, 1, 2, 5,  2};
        vecs[11] = '{0, 1, 0, 1, 2, 5,  2};
        vecs[12] = '{1, 1, 0, 1, 3, 5,  3};
        vecs[13] = '{0, 1, 1, 1, 2, 9,  3};
        vecs[14] = '{0, 1, 1, 1, 1, 12, 3};
        vecs[15] = '{0, 1, 1, 0, 0, 0,  3};
        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].det, vecs[i].en, 1'b0, 1'b0, vecs[i].rdy);
            check($sformatf("vec%0d.valid", i), 32'(evt_valid), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d.level", i), 32'(fifo_level), 32'(vecs[i].exp_level));
            check($sformatf("vec%0d.ts", i),    32'(evt_ts), 32'(vecs[i].exp_ts));
            check($sformatf("vec%0d.det", i),   32'(det_cnt), 32'(vecs[i].exp_det));
            check($sformatf("vec%0d.drop", i),  32'(drop_cnt), 32'd0);
        end

        // Overflow: 6 pulses into an unserviced FIFO keep the first four
        drive(0, 0, 0, 1, 0);
        for (int i = 0; i < 6; i++) drive(1, 1, 0, 0, 0);
        check("ovf.level", 32'(fifo_level), 32'd4);
        check("ovf.det",   32'(det_cnt), 32'd6);
        check("ovf.drop",  32'(drop_cnt), 32'd2);
        check("ovf.ovf",   32'(ovf), 32'd1);
        check("ovf.head",  32'(evt_ts), 32'd0);

        // Full FIFO with simultaneous push and pop: nothing dropped, ts=6 becomes tail
        drive(1, 1, 0, 0, 1);
        check("fullpp.level", 32'(fifo_level), 32'd4);
        check("fullpp.drop",  32'(drop_cnt), 32'd2);
        check("fullpp.det",   32'(det_cnt), 32'd7);
        check_state("fullpp");

        // Drain with en=0: det_in ignored, pops continue, ovf sticky
        for (int i = 0; i < 4; i++) drive(1, 0, 0, 0, 1);
        check("drain.valid", 32'(evt_valid), 32'd0);
        check("drain.det",   32'(det_cnt), 32'd7);
        check("drain.ovf",   32'(ovf), 32'd1);
        drive(0, 0, 0, 0, 1);
        check("idle_rdy.level", 32'(fifo_level), 32'd0);

        // Soft clear behaves like reset and discards a coincident pulse
        drive(1, 1, 0, 0, 0);
        drive(1, 1, 1, 0, 0);
        check("clr.level", 32'(fifo_level), 32'd0);
        check("clr.ovf",   32'(ovf), 32'd0);
        check("clr.det",   32'(det_cnt), 32'd0);
        check_state("clr");

        // Timestamp wrap: pulses at 0xFFFF and the following cycle
        drive(0, 0, 0, 1, 0);
        for (int i = 0; i < 65535; i++) drive(0, 1, 0, 0, 0);
        drive(1, 1, 0, 0, 0);
        drive(1, 1, 0, 0, 0);
        check("wrap.level", 32'(fifo_level), 32'd2);
        check("wrap.head0", 32'(evt_ts), 32'h0000_FFFF);
        drive(0, 0, 0, 0, 1);
        check("wrap.head1", 32'(evt_ts), 32'd0);
        check("wrap.level1", 32'(fifo_level), 32'd1);
        drive(0, 0, 0, 0, 1);
        check("wrap.empty", 32'(evt_valid), 32'd0);

        // Saturation of det_cnt with a serviced FIFO
        drive(0, 0, 0, 1, 0);
        for (int i = 0; i < 300; i++) drive(1, 1, 0, 0, 1);
        check("sat.det",  32'(det_cnt), 32'd255);
        check("sat.drop", 32'(drop_cnt), 32'd0);
        check_state("sat");

        // Saturation of drop_cnt with an unserviced FIFO
        drive(0, 0, 0, 1, 0);
        for (int i = 0; i < 300; i++) drive(1, 1, 0, 0, 0);
        check("satdrop.det",  32'(det_cnt), 32'd255);
        check("satdrop.drop", 32'(drop_cnt), 32'd255);

        // Reset mid-operation with level=3 and ovf=1, plus a pulse in the reset cycle
        drive(0, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) drive(1, 1, 0, 0, 0);
        drive(0, 1, 0, 0, 1);
        check("mid.level", 32'(fifo_level), 32'd3);
        check("mid.ovf",   32'(ovf), 32'd1);
        drive(1, 1, 0, 1, 1);
        check("midrst.valid", 32'(evt_valid), 32'd0);
        check("midrst.level", 32'(fifo_level), 32'd0);
        check("midrst.ovf",   32'(ovf), 32'd0);
        check("midrst.det",   32'(det_cnt), 32'd0);
        check("midrst.ts",    32'(evt_ts), 32'd0);
        drive(1, 1, 0, 0, 0);
        check("postrst.level", 32'(fifo_level), 32'd1);
        check("postrst.ts",    32'(evt_ts), 32'd0);
        check("postrst.det",   32'(det_cnt), 32'd1);
        check_state("postrst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
